// File: rtl/serial_halfadd_seq.sv
// serial_halfadd_seq: feeds two operands LSB-first into a 1-bit half adder and collects the sum/carry words.
module serial_halfadd_seq #(
    parameter int WIDTH = 4
) (
    input  logic             SYSCLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a,
    output logic             b,
    input  logic             sum,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_carry,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0] res_s_q, res_s_d, res_c_q, res_c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_s_d = res_s_q;
        res_c_d = res_c_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                state_d = SHIFT;
                sa_d    = in_a;
                sb_d    = in_b;
                cnt_d   = '0;
            end
        end else if (state_q == SHIFT) begin
            // shift-based insert keeps WIDTH=1 legal where a [WIDTH-1:1] slice would not be
            res_s_d = (res_s_q >> 1) | (WIDTH'(sum) << (WIDTH - 1));
            res_c_d = (res_c_q >> 1) | (WIDTH'(c) << (WIDTH - 1));
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
        end else if (out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_s_q <= '0;
            res_c_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_s_q <= res_s_d;
            res_c_q <= res_c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !RESET;
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign out_valid = (state_q == DONE);
    assign a         = (state_q == SHIFT) && sa_q[0];
    assign b         = (state_q == SHIFT) && sb_q[0];
    assign out_sum   = res_s_q;
    assign out_carry = res_c_q;
endmodule

// File: tb/tb_serial_halfadd_seq.sv
// tb_serial_halfadd_seq: randomized and directed checks of the serial half-add sequencer against a word-level model.
module tb_serial_halfadd_seq;
    logic       SYSCLK = 0;
    logic       RESET = 1;
    logic       in_valid = 0, out_ready = 1;
    logic [3:0] in_a = 0, in_b = 0;
    logic       in_ready, a, b, sum, c, out_valid, busy;
    logic [3:0] out_sum, out_carry;
    int         checks = 0, errors = 0, cyc = 0;
    int         acc_cyc[$];
    logic       hold_valid = 0;

    serial_halfadd_seq #(.WIDTH(4)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .a(a), .b(b), .sum(sum), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .busy(busy)
    );

    // behavioural lib_math half adder
    assign sum = a ^ b;
    assign c   = a & b;

    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a"}, a, 0);
        check({tag, "_b"}, b, 0);
        check({tag, "_ov"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // drive one pair, check every serial bit, the result word and the handshake; bp = stall cycles
    task automatic send(input logic [3:0] x, input logic [3:0] y, input int bp);
        int n = 0;
        logic [3:0] es = x ^ y, ec = x & y;
        in_a = x; in_b = y; in_valid = 1;
        out_ready = (bp == 0);
        while (!in_ready && n < 20) begin @(negedge SYSCLK); n++; end
        if (n == 20) begin check("accept_timeout", 0, 1); in_valid = 0; return; end
        @(posedge SYSCLK);
        acc_cyc.push_back(cyc);
        #1 if (!hold_valid) in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge SYSCLK);
            check("a_bit", a, x[i]);
            check("b_bit", b, y[i]);
            check("ov_early", out_valid, 0);
            check("in_ready_shift", in_ready, 0);
        end
        @(negedge SYSCLK);
        check("ov_rise", out_valid, 1);
        check("out_sum", out_sum, es);
        check("out_carry", out_carry, ec);
        check("ab_done", {a, b}, 0);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1; in_a = ~x; in_b = y + 4'd5;
            @(negedge SYSCLK);
            check("bp_ov", out_valid, 1);
            check("bp_sum", out_sum, es);
            check("bp_carry", out_carry, ec);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
        end
        if (bp > 0) begin
            in_valid = 0;
            out_ready = 1;
        end
        @(negedge SYSCLK);
        check("ov_fall", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        #3;
        check("rst_in_ready", in_ready, 0);
        check_idle_outputs("rst");
        check("rst_sum", out_sum, 0);
        check("rst_carry", out_carry, 0);
        repeat (2) @(negedge SYSCLK);
        RESET = 0;
        @(negedge SYSCLK);
        check("rel_in_ready", in_ready, 1);

        send(4'b0101, 4'b0011, 0);
        send(4'hF, 4'hF, 0);
        send(4'h0, 4'h0, 0);
        send(4'hC, 4'h6, 5);

        // reset while bit 2 is on the wires
        in_a = 4'h7; in_b = 4'h5; in_valid = 1;
        @(posedge SYSCLK); #1 in_valid = 0;
        repeat (3) @(negedge SYSCLK);
        check("mid_a_bit2", a, 1);
        #2 RESET = 1;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge SYSCLK);
        RESET = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge SYSCLK);
            check("mid_no_ov", out_valid, 0);
        end
        send(4'h9, 4'h3, 0);

        // back-to-back with in_valid held
        acc_cyc.delete();
        hold_valid = 1;
        for (int k = 0; k < 3; k++) send(4'($urandom), 4'($urandom), 0);
        hold_valid = 0;
        in_valid = 0;
        @(negedge SYSCLK);
        for (int k = 1; k < acc_cyc.size(); k++)
            check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 6);
        check("b2b_count", acc_cyc.size(), 3);

        for (int k = 0; k < 20; k++)
            send(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_halfadd_seq.md
# serial_halfadd_seq

Bit-serial operand sequencer and result collector for the `lib_math` 1-bit half adder. It accepts two WIDTH-bit operands through a valid/ready handshake and drives them LSB-first, one bit per clock, onto the adder's `a`/`b` inputs. Each cycle it captures the adder's combinational `sum`/`c` outputs. It returns two WIDTH-bit words: `out_sum` (bitwise `a^b`) and `out_carry` (bitwise `a&b`), through a second valid/ready handshake. The block sits directly upstream of `lib_math` and also consumes its outputs.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits, minimum 1.

Ports:
- `SYSCLK`, in, 1: the single clock; all state changes on the rising edge.
- `RESET`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: operand pair is valid.
- `in_ready`, out, 1: block can accept an operand pair.
- `in_a`, in, WIDTH: operand A.
- `in_b`, in, WIDTH: operand B.
- `a`, out, 1: serial bit of A, connected to `lib_math.a`.
- `b`, out, 1: serial bit of B, connected to `lib_math.b`.
- `sum`, in, 1: from `lib_math.sum`.
- `c`, in, 1: from `lib_math.c`.
- `out_valid`, out, 1: result words are valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_sum`, out, WIDTH: collected sum bits, with bit i taken from operand bit i.
- `out_carry`, out, WIDTH: collected carry bits, with bit i taken from operand bit i.
- `busy`, out, 1: high when the state is SHIFT or DONE.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready` at a rising edge: load shift registers `sa`<=`in_a` and `sb`<=`in_b`, set `cnt`<=0, and go to SHIFT.
- **SHIFT**
  - `a`=`sa[0]` and `b`=`sb[0]`, driven directly from registers. `lib_math` is combinational, so `sum`/`c` are valid in the same cycle.
  - At each edge:
    - `res_s`<={`sum`, `res_s[WIDTH-1:1]`}.
    - `res_c`<={`c`, `res_c[WIDTH-1:1]`}.
    - `sa` and `sb` shift right by one, filling with 0.
    - `cnt`<=`cnt`+1.
  - When `cnt`==WIDTH-1 at the edge (the last bit is being captured), go to DONE.
  - `cnt` width is clog2(WIDTH+1); `cnt` never wraps.
- **DONE**
  - `out_valid`=1. `out_sum`=`res_s` and `out_carry`=`res_c`, held stable.
  - When `out_ready`=1 at an edge, go to IDLE.
- `a`=`b`=0 whenever the state is not SHIFT.
- `in_ready`=0 in SHIFT and DONE. `in_valid` is ignored there, and `in_a`/`in_b` are not sampled.
- Simultaneous events:
  - In DONE with `out_ready`=1, the next operand pair cannot be accepted in the same cycle. The earliest acceptance is the following cycle, in IDLE.
  - `sum`/`c` are ignored outside SHIFT.
- **Reset mid-operation** (RESET asserted in any state):
  - Immediately, without waiting for a clock: state←IDLE; `sa`, `sb`, `res_s`, `res_c` and `cnt`←0; the in-flight transfer is discarded.
  - `in_ready` is forced to 0 while RESET=1.
- Reset values of outputs:
  - `in_ready`=0 while RESET is high, and 1 once released.
  - `a`=0, `b`=0, `out_valid`=0, `out_sum`=0, `out_carry`=0, `busy`=0.

## Timing
- Acceptance edge E0: state becomes SHIFT.
- Cycle after E0: bit 0 appears on `a`/`b`.
- Bit i is presented during the cycle after edge E0+i and captured at edge E0+i+1.
- Edge E0+WIDTH: last capture; state becomes DONE.
- `out_valid` rises WIDTH cycles after the acceptance edge and stays high until the edge with `out_ready`=1.
- Maximum throughput is one operand pair per WIDTH+2 cycles, when `out_ready` is held at 1.
- `out_valid`, `in_ready` and `busy` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
All scenarios use WIDTH=4.
- Reset behaviour:
  - Assert RESET asynchronously, between clock edges -> all outputs go to reset values at once; `in_ready`=0 during reset.
  - Release RESET -> `in_ready`=1 at the next cycle.
- Basic transfer:
  - Stimulus: `in_a`=4'b0101, `in_b`=4'b0011, `out_ready`=1.
  - Required response: `a` sequence 1,0,1,0 and `b` sequence 1,1,0,0 over 4 cycles; then `out_sum`=4'b0110 and `out_carry`=4'b0001 with `out_valid` high for exactly 1 cycle, 4 cycles after acceptance.
- Extremes:
  - `in_a`=4'hF, `in_b`=4'hF -> `out_sum`=0, `out_carry`=4'hF.
  - `in_a`=4'h0, `in_b`=4'h0 -> `out_sum`=0, `out_carry`=0.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles after `out_valid` rises.
  - Required response: `out_valid` and the result words stay stable, `in_ready` stays 0, and a new `in_valid` is ignored. Accept proceeds only after `out_ready`=1 and the return to IDLE.
- Reset mid-SHIFT:
  - Stimulus: assert RESET after bit 2 is presented.
  - Required response: `a`=`b`=0 immediately; `out_valid` never rises; the next transfer, `in_a`=4'h9, `in_b`=4'h3, yields `out_sum`=4'hA and `out_carry`=4'h1.
- Back-to-back:
  - Stimulus: 3 pairs with `in_valid` held high and `out_ready`=1.
  - Required response: acceptances are spaced exactly 6 cycles apart, and every result matches `in_a`^`in_b` / `in_a`&`in_b`.
